int_controller: RTL and testbench

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller_if.sv | 12 +
 rtl/int_controller.sv | 115 +++++++++++
 tb/tb_int_controller.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_controller_if.sv
// CPU I/O bus between a PicoBlaze-style CPU and the interrupt controller:
// the OUT strobe, port address and write data, plus the combinational read data path.
interface int_controller_if;
  logic       io_strb;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (output io_strb, port_id, out_port, input rd_data, rd_hit);
  modport slave  (input io_strb, port_id, out_port, output rd_data, rd_hit);
endinterface

// File: rtl/int_controller.sv
// Eight-source, rising-edge interrupt controller with a MASK/PEND/ID/EOI register window.
// Each request produces a fixed-width cpu_interrupt pulse, then waits for an EOI write.
module int_controller #(
  parameter logic [7:0]  BASE_PORT    = 8'hF0,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        irq_in,
  int_controller_if.slave   bus,
  output logic              cpu_interrupt
);

  localparam logic [7:0] ADDR_MASK  = BASE_PORT;
  localparam logic [7:0] ADDR_PEND  = BASE_PORT + 8'd1;
  localparam logic [7:0] ADDR_ID    = BASE_PORT + 8'd2;
  localparam logic [7:0] ADDR_EOI   = BASE_PORT + 8'd3;
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [7:0] mask, pend, irq_prev;
  logic [7:0] rise, active, clr_bits, id_value;
  logic [2:0] winner;
  logic       any_active, found;
  logic       wr_mask, wr_pend, wr_eoi;

  always_comb begin
    wr_mask    = bus.io_strb && (bus.port_id == ADDR_MASK);
    wr_pend    = bus.io_strb && (bus.port_id == ADDR_PEND);
    wr_eoi     = bus.io_strb && (bus.port_id == ADDR_EOI);
    rise       = irq_in & ~irq_prev;
    active     = pend & mask;
    any_active = |active;
    clr_bits   = wr_pend ? bus.out_port : '0;
  end

  // Lowest set bit of active wins; the found flag keeps later bits from overriding it.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (active[i] && !found) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
    id_value = any_active ? {1'b1, 4'b0000, winner} : '0;
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_hit  = 1'b1;
    case (bus.port_id)
      ADDR_MASK: bus.rd_data = mask;
      ADDR_PEND: bus.rd_data = pend;
      ADDR_ID:   bus.rd_data = id_value;
      ADDR_EOI:  bus.rd_data = '0;
      default:   bus.rd_hit  = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (any_active) begin
          state_next = REQ;
          cnt_next   = PULSE_LOAD;
        end
      end
      REQ: begin
        if (cnt == '0) begin
          state_next = SERVICE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A rise is OR-ed in after the clear, so a same-cycle set beats write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask          <= '0;
      pend          <= '0;
      irq_prev      <= '0;
      state         <= IDLE;
      cnt           <= '0;
      cpu_interrupt <= 1'b0;
    end else begin
      irq_prev      <= irq_in;
      pend          <= (pend & ~clr_bits) | rise;
      state         <= state_next;
      cnt           <= cnt_next;
      cpu_interrupt <= (state == REQ);
      if (wr_mask) begin
        mask <= bus.out_port;
      end
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: register decode, pulse timing, priority,
// masking, SERVICE hold-off, set-vs-clear collision and mid-pulse reset.
module tb_int_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = '0;
  logic       cpu_interrupt;
  int         checks = 0;
  int         errors = 0;

  int_controller_if bus ();

  int_controller #(.BASE_PORT(8'hF0), .PULSE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .bus           (bus.slave),
    .cpu_interrupt (cpu_interrupt)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.io_strb  = 1'b1;
    bus.port_id  = addr;
    bus.out_port = data;
    @(negedge clk);
    bus.io_strb  = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus.port_id = addr;
    #1;
    data = bus.rd_data;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", cpu_interrupt); end
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      cpu_read(8'hF0 + 8'(a), d);
      checks++;
      if (d !== 8'h00 || bus.rd_hit !== 1'b1) begin
        errors++; $display("FAIL reset_read%0d: got %h hit %b want 00 hit 1", a, d, bus.rd_hit);
      end
    end
    cpu_read(8'h10, d);
    checks++;
    if (d !== 8'h00 || bus.rd_hit !== 1'b0) begin errors++; $display("FAIL unmapped_read: got %h hit %b want 00 hit 0", d, bus.rd_hit); end
    cpu_write(8'h10, 8'hFF);
    cpu_write(8'hF4, 8'hFF);
    cpu_read(8'hF0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unmapped_write: MASK got %h want 00", d); end
  endtask

  task automatic test_single;
    logic [7:0] d;
    int first, width;
    cpu_write(8'hF0, 8'h04);
    cpu_read(8'hF0, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL mask_rw: got %h want 04", d); end
    @(negedge clk);
    irq_in = 8'h04;
    first = 0; width = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_interrupt) begin width++; if (first == 0) first = k; end
      if (k == 1) begin
        irq_in = '0;
        bus.port_id = 8'hF1;
        #1;
        checks++;
        if (bus.rd_data !== 8'h04) begin errors++; $display("FAIL single_pend: got %h want 04", bus.rd_data); end
      end
    end
    checks++;
    if (first !== 3 || width !== 4) begin errors++; $display("FAIL single_pulse: start %0d width %0d want 3 and 4", first, width); end
    cpu_read(8'hF2, d);
    checks++;
    if (d !== 8'h82) begin errors++; $display("FAIL single_id: got %h want 82", d); end
    cpu_write(8'hF1, 8'h04);
    cpu_read(8'hF1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL single_w1c: got %h want 00", d); end
    cpu_write(8'hF3, 8'h00);
    width = 0;
    repeat (6) begin @(negedge clk); if (cpu_interrupt) width++; end
    checks++;
    if (width !== 0) begin errors++; $display("FAIL single_no_retrigger: high %0d cycles want 0", width); end
  endtask

  task automatic test_priority;
    logic [7:0] d;
    int first, width;
    cpu_write(8'hF0, 8'hFF);
    @(negedge clk);
    irq_in = 8'h22;
    @(negedge clk);
    irq_in = '0;
    bus.port_id = 8'hF2;
    #1;
    checks++;
    if (bus.rd_data !== 8'h81) begin errors++; $display("FAIL prio_id_first: got %h want 81", bus.rd_data); end
    repeat (10) @(negedge clk);
    cpu_write(8'hF1, 8'h02);
    cpu_read(8'hF2, d);
    checks++;
    if (d !== 8'h85) begin errors++; $display("FAIL prio_id_second: got %h want 85", d); end
    cpu_write(8'hF3, 8'h00);
    first = 0; width = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cpu_interrupt) begin width++; if (first == 0) first = k; end
    end
    checks++;
    if (first !== 2 || width !== 4) begin errors++; $display("FAIL back_to_back: start %0d width %0d want 2 and 4", first, width); end
    cpu_write(8'hF1, 8'h20);
    cpu_write(8'hF3, 8'h00);
    cpu_read(8'hF2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL prio_id_empty: got %h want 00", d); end
  endtask

  task automatic test_masked;
    logic [7:0] d;
    int first, width;
    cpu_write(8'hF0, 8'h00);
    @(negedge clk);
    irq_in = 8'h08;
    width = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) irq_in = '0;
      if (cpu_interrupt) width++;
    end
    checks++;
    if (width !== 0) begin errors++; $display("FAIL masked_quiet: high %0d cycles want 0", width); end
    cpu_read(8'hF1, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL masked_pend: got %h want 08", d); end
    cpu_write(8'hF0, 8'h08);
    first = 0; width = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cpu_interrupt) begin width++; if (first == 0) first = k; end
    end
    checks++;
    if (first !== 2 || width !== 4) begin errors++; $display("FAIL unmask_pulse: start %0d width %0d want 2 and 4", first, width); end
    cpu_write(8'hF1, 8'h08);
    cpu_write(8'hF3, 8'h00);
  endtask

  task automatic test_service;
    logic [7:0] d;
    int first, width;
    cpu_write(8'hF0, 8'hFF);
    @(negedge clk);
    irq_in = 8'h40;
    first = 0; width = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) irq_in = '0;
      if (cpu_interrupt) begin width++; if (first == 0) first = k; end
    end
    checks++;
    if (first !== 3 || width !== 4) begin errors++; $display("FAIL service_first: start %0d width %0d want 3 and 4", first, width); end
    @(negedge clk);
    irq_in = 8'h01;
    width = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) irq_in = '0;
      if (cpu_interrupt) width++;
    end
    checks++;
    if (width !== 0) begin errors++; $display("FAIL service_holdoff: high %0d cycles want 0", width); end
    cpu_read(8'hF1, d);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL service_pend: got %h want 41", d); end
    cpu_read(8'hF2, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL service_id: got %h want 80", d); end
    cpu_write(8'hF3, 8'h00);
    first = 0; width = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cpu_interrupt) begin width++; if (first == 0) first = k; end
    end
    checks++;
    if (first !== 2 || width !== 4) begin errors++; $display("FAIL service_eoi_pulse: start %0d width %0d want 2 and 4", first, width); end
    cpu_write(8'hF1, 8'h41);
    cpu_write(8'hF3, 8'h00);
  endtask

  task automatic test_eoi_in_req;
    int first, width;
    cpu_write(8'hF0, 8'h02);
    @(negedge clk);
    irq_in = 8'h02;
    first = 0; width = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) irq_in = '0;
      bus.io_strb = (k == 3);
      bus.port_id = 8'hF3;
      if (cpu_interrupt) begin width++; if (first == 0) first = k; end
    end
    bus.io_strb = 1'b0;
    checks++;
    if (first !== 3 || width !== 4) begin errors++; $display("FAIL eoi_in_req: start %0d width %0d want 3 and 4", first, width); end
    width = 0;
    repeat (5) begin @(negedge clk); if (cpu_interrupt) width++; end
    checks++;
    if (width !== 0) begin errors++; $display("FAIL eoi_in_req_hold: high %0d cycles want 0", width); end
    cpu_write(8'hF1, 8'h02);
    cpu_write(8'hF3, 8'h00);
  endtask

  task automatic test_set_wins;
    logic [7:0] d;
    cpu_write(8'hF0, 8'h00);
    @(negedge clk);
    irq_in = 8'h18;
    @(negedge clk);
    irq_in = '0;
    cpu_read(8'hF1, d);
    checks++;
    if (d !== 8'h18) begin errors++; $display("FAIL setwin_setup: got %h want 18", d); end
    @(negedge clk);
    irq_in       = 8'h10;
    bus.io_strb  = 1'b1;
    bus.port_id  = 8'hF1;
    bus.out_port = 8'h18;
    @(negedge clk);
    bus.io_strb  = 1'b0;
    irq_in       = '0;
    cpu_read(8'hF1, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL set_wins: got %h want 10", d); end
    cpu_write(8'hF1, 8'h10);
    cpu_read(8'hF1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL setwin_clear: got %h want 00", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int width;
    cpu_write(8'hF0, 8'h01);
    @(negedge clk);
    irq_in = 8'h01;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_interrupt !== 1'b1) begin errors++; $display("FAIL rstmid_pulse_up: got %b want 1", cpu_interrupt); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_interrupt !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", cpu_interrupt); end
    for (int a = 0; a < 4; a++) begin
      bus.port_id = 8'hF0 + 8'(a);
      #1;
      checks++;
      if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_read%0d: got %h want 00", a, bus.rd_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.port_id = 8'hF1;
    #1;
    checks++;
    if (bus.rd_data !== 8'h01) begin errors++; $display("FAIL held_source_rise: PEND got %h want 01", bus.rd_data); end
    width = 0;
    repeat (6) begin @(negedge clk); if (cpu_interrupt) width++; end
    checks++;
    if (width !== 0) begin errors++; $display("FAIL rstmid_masked: high %0d cycles want 0", width); end
    irq_in = '0;
    cpu_write(8'hF1, 8'hFF);
  endtask

  initial begin
    bus.io_strb  = 1'b0;
    bus.port_id  = 8'h00;
    bus.out_port = 8'h00;
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_service();
    test_eoi_in_req();
    test_set_wins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
